// File: rtl/decode_scoreboard.sv
// LC-3b decode hazard scoreboard: per-register and CC in-flight write counters gating issue.
// stall/issue are combinational; counters, err and stall_cycles update on the rising edge.
module decode_scoreboard #(
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b0,
  parameter int PERF_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic [2:0]        dec_src1,
  input  logic [2:0]        dec_src2,
  input  logic              dec_src1_used,
  input  logic              dec_src2_used,
  input  logic [2:0]        dec_dest,
  input  logic              dec_ld_reg,
  input  logic              dec_uses_cc,
  input  logic              dec_ld_cc,
  input  logic              issue_ready,
  input  logic              wb_valid,
  input  logic              wb_ld_reg,
  input  logic              wb_ld_cc,
  input  logic [2:0]        wb_dest,
  input  logic              kill_valid,
  input  logic              kill_ld_reg,
  input  logic              kill_ld_cc,
  input  logic [2:0]        kill_dest,
  output logic              stall,
  output logic              issue,
  output logic [7:0]        reg_busy,
  output logic              cc_busy,
  output logic              err,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [8];
  logic [CNT_W-1:0] cnt_cc;
  logic [CNT_W-1:0] cnt_nxt [8];
  logic [CNT_W-1:0] cnt_cc_nxt;
  logic [7:0]       wb_hit, kill_hit, inc_hit, pend, sat, upd_err;
  logic             wb_cc_hit, kill_cc_hit, pend_cc, sat_cc, cc_err;
  logic             hazard;

  // Saturating add/subtract; bit CNT_W flags an attempted under/overflow.
  function automatic logic [CNT_W:0] upd(input logic [CNT_W-1:0] cur, input logic inc,
                                         input logic d1, input logic d2);
    int n;
    n = int'(cur) + int'(inc) - int'(d1) - int'(d2);
    if (n < 0)                 upd = {1'b1, {CNT_W{1'b0}}};
    else if (n > int'(CNT_MAX)) upd = {1'b1, CNT_MAX};
    else                       upd = {1'b0, n[CNT_W-1:0]};
  endfunction

  assign wb_cc_hit   = wb_valid & wb_ld_cc;
  assign kill_cc_hit = kill_valid & kill_ld_cc;

  always_comb begin
    for (int r = 0; r < 8; r++) begin
      wb_hit[r]   = wb_valid & wb_ld_reg & (wb_dest == 3'(r));
      kill_hit[r] = kill_valid & kill_ld_reg & (kill_dest == 3'(r));
      sat[r]      = (cnt[r] == CNT_MAX);
      // Write-through regfile: the final pending write landing this cycle is visible now.
      pend[r]     = (cnt[r] != '0) &&
                    !(WB_BYPASS && (cnt[r] == CNT_ONE) && (wb_hit[r] || kill_hit[r]));
    end
    pend_cc = (cnt_cc != '0) &&
              !(WB_BYPASS && (cnt_cc == CNT_ONE) && (wb_cc_hit || kill_cc_hit));
    sat_cc  = (cnt_cc == CNT_MAX);
  end

  assign hazard = (dec_src1_used & pend[dec_src1]) |
                  (dec_src2_used & pend[dec_src2]) |
                  (dec_uses_cc & pend_cc) |
                  (dec_ld_reg & sat[dec_dest]) |
                  (dec_ld_cc & sat_cc);

  assign stall = dec_valid & (hazard | ~issue_ready);
  assign issue = dec_valid & ~stall;

  always_comb begin
    for (int r = 0; r < 8; r++) begin
      inc_hit[r] = issue & dec_ld_reg & (dec_dest == 3'(r));
      {upd_err[r], cnt_nxt[r]} = upd(cnt[r], inc_hit[r], wb_hit[r], kill_hit[r]);
    end
    {cc_err, cnt_cc_nxt} = upd(cnt_cc, issue & dec_ld_cc, wb_cc_hit, kill_cc_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 8; r++) cnt[r] <= '0;
      cnt_cc       <= '0;
      err          <= 1'b0;
      stall_cycles <= '0;
    end else begin
      for (int r = 0; r < 8; r++) cnt[r] <= cnt_nxt[r];
      cnt_cc <= cnt_cc_nxt;
      err    <= err | cc_err | (|upd_err);
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

  always_comb begin
    for (int r = 0; r < 8; r++) reg_busy[r] = (cnt[r] != '0);
  end
  assign cc_busy = (cnt_cc != '0);

endmodule
